// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: one outstanding imem read per PC, registered handoff to decode,
// stale-response draining after redirects, and bus-error / watchdog fault reporting.
module ifu_fetch #(
   parameter int PC_WIDTH   = 32,
   parameter int INST_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic                  branch_taken,
   output logic                  pc_enable,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [PC_WIDTH-1:0]   imem_req_addr,
   input  logic                  imem_resp_valid,
   output logic                  imem_resp_ready,
   input  logic [INST_WIDTH-1:0] imem_resp_data,
   input  logic                  imem_resp_err,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [INST_WIDTH-1:0] inst,
   output logic [PC_WIDTH-1:0]   inst_pc,
   output logic                  inst_fault
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic [PC_WIDTH-1:0]   inst_pc_q, inst_pc_d;
   logic                  fault_q, fault_d;
   logic                  tmo_q, tmo_d;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  timeout_hit;

   // cnt_inc is the number of WAIT cycles including the current one
   assign cnt_inc     = cnt_q + 1'b1;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TIMEOUT_C);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         inst_q    <= '0;
         inst_pc_q <= '0;
         fault_q   <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ:   if (imem_req_ready) state_d = branch_taken ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            if (imem_resp_valid)   state_d = branch_taken ? S_REQ : S_HOLD;
            else if (branch_taken) state_d = S_DRAIN;
            else if (timeout_hit)  state_d = S_HOLD;
         end
         // after a timeout the original request is still in flight and must be absorbed
         S_HOLD:  if (inst_ready || branch_taken) state_d = tmo_q ? S_DRAIN : S_REQ;
         S_DRAIN: if (imem_resp_valid) state_d = S_REQ;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      fault_d   = fault_q;
      tmo_d     = tmo_q;
      case (state_q)
         S_REQ: cnt_d = '0;
         S_WAIT: begin
            cnt_d = cnt_inc;
            if (imem_resp_valid && !branch_taken) begin
               inst_d    = imem_resp_data;
               inst_pc_d = pc;
               fault_d   = imem_resp_err;
               tmo_d     = 1'b0;
            end else if (!imem_resp_valid && !branch_taken && timeout_hit) begin
               inst_d    = '0;
               inst_pc_d = pc;
               fault_d   = 1'b1;
               tmo_d     = 1'b1;
            end
         end
         S_HOLD: if (inst_ready || branch_taken) tmo_d = 1'b0;
         default: ;
      endcase
   end

   always_comb begin
      imem_req_valid  = (state_q == S_REQ);
      imem_resp_ready = (state_q == S_WAIT) || (state_q == S_DRAIN);
      inst_valid      = (state_q == S_HOLD);
      inst_fault      = (state_q == S_HOLD) && fault_q;
      pc_enable       = (state_q != S_IDLE) &&
                        (((state_q == S_HOLD) && inst_ready) || branch_taken);
   end

   assign imem_req_addr = pc;
   assign inst          = inst_q;
   assign inst_pc       = inst_pc_q;

endmodule
